scaler_block_sequencer: RTL and testbench

- Controls the block-floating-point scaling datapath.
- Frames incoming complex samples into BLOCK_SIZE blocks aligned to syncTo10ms, and drives write addressing of an external ping-pong sample buffer.
- Tracks per-block peak I/Q magnitude and derives the block shift.
- Sequences readout of each completed bank, with a header strobe, toward the scaling multiplier.

---
 rtl/scaler_block_sequencer_pkg.sv | 32 +++
 rtl/scaler_block_sequencer_if.sv | 43 ++++
 rtl/scaler_block_sequencer_peak_to_shift.sv | 24 ++
 rtl/scaler_block_sequencer.sv | 142 ++++++++++++++
 tb/tb_scaler_block_sequencer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/scaler_block_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scaler_block_sequencer_pkg
// Purpose  : Shared sizes, sequencer state type and saturating magnitude.
// Revision : 1.0 - initial release
// ============================================================================
package scaler_block_sequencer_pkg;

  localparam int INPUT_DATA_BITWIDTH  = 32;
  localparam int BLOCK_SIZE           = 1024;
  localparam int ADDR_BITWIDTH        = 10;
  localparam int SHIFT_BITWIDTH       = 4;
  localparam int BLOCK_COUNT_BITWIDTH = 8;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  // |x| for a 16-bit two's complement value; -32768 clips to 32767.
  function automatic logic [15:0] sat_abs(input logic [15:0] x);
    if (x == 16'h8000) begin
      return 16'h7fff;
    end else if (x[15]) begin
      return (~x) + 16'd1;
    end else begin
      return x;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/scaler_block_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : scaler_block_sequencer_if
// Purpose  : Sample input and buffer/readout control bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface scaler_block_sequencer_if
  import scaler_block_sequencer_pkg::*;
#(
  parameter int INPUT_DATA_BITWIDTH  = scaler_block_sequencer_pkg::INPUT_DATA_BITWIDTH,
  parameter int ADDR_BITWIDTH        = scaler_block_sequencer_pkg::ADDR_BITWIDTH,
  parameter int SHIFT_BITWIDTH       = scaler_block_sequencer_pkg::SHIFT_BITWIDTH,
  parameter int BLOCK_COUNT_BITWIDTH = scaler_block_sequencer_pkg::BLOCK_COUNT_BITWIDTH
);
  logic                            syncTo10ms;
  logic [INPUT_DATA_BITWIDTH-1:0]  inData;
  logic                            inValid;
  logic                            wrEn;
  logic                            wrBank;
  logic [ADDR_BITWIDTH-1:0]        wrAddr;
  logic                            rdEn;
  logic                            rdBank;
  logic [ADDR_BITWIDTH-1:0]        rdAddr;
  logic                            rdLast;
  logic                            hdrValid;
  logic [15:0]                     blockPeak;
  logic [SHIFT_BITWIDTH-1:0]       blockShift;
  logic [BLOCK_COUNT_BITWIDTH-1:0] blockCount;
  logic                            syncErr;

  modport master (
    output syncTo10ms, inData, inValid,
    input  wrEn, wrBank, wrAddr, rdEn, rdBank, rdAddr, rdLast, hdrValid,
    input  blockPeak, blockShift, blockCount, syncErr
  );

  modport slave (
    input  syncTo10ms, inData, inValid,
    output wrEn, wrBank, wrAddr, rdEn, rdBank, rdAddr, rdLast, hdrValid,
    output blockPeak, blockShift, blockCount, syncErr
  );
endinterface
`default_nettype wire

// File: rtl/scaler_block_sequencer_peak_to_shift.sv
`default_nettype none
// ============================================================================
// Module   : scaler_block_sequencer_peak_to_shift
// Purpose  : Peak magnitude to normalising left shift (14 - msb index).
// Revision : 1.0 - initial release
// ============================================================================
module scaler_block_sequencer_peak_to_shift #(
  parameter int SHIFT_BITWIDTH = 4
) (
  input  wire logic [15:0]               i_peak,
  output logic      [SHIFT_BITWIDTH-1:0] o_shift
);

  // Ascending scan: the highest set bit is the last one to write o_shift.
  always_comb begin
    o_shift = SHIFT_BITWIDTH'(14);
    for (int i = 0; i < 15; i++) begin
      if (i_peak[i]) o_shift = SHIFT_BITWIDTH'(14 - i);
    end
    if (i_peak[15]) o_shift = '0;
  end

endmodule
`default_nettype wire

// File: rtl/scaler_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : scaler_block_sequencer
// Purpose  : Frames samples into ping-pong banks, tracks block peak/shift and
//            sequences readout of each finished bank.
// Revision : 1.0 - initial release
// ============================================================================
module scaler_block_sequencer
  import scaler_block_sequencer_pkg::*;
#(
  parameter int INPUT_DATA_BITWIDTH  = 32,
  parameter int BLOCK_SIZE           = 1024,
  parameter int ADDR_BITWIDTH        = 10,
  parameter int SHIFT_BITWIDTH       = 4,
  parameter int BLOCK_COUNT_BITWIDTH = 8
) (
  input  wire logic                clk,
  input  wire logic                rst,
  scaler_block_sequencer_if.slave  bus
);

  localparam logic [ADDR_BITWIDTH-1:0] LAST_ADDR = ADDR_BITWIDTH'(BLOCK_SIZE - 1);

  state_e                          state_q, state_d;
  logic [ADDR_BITWIDTH-1:0]        count_q, count_d;
  logic [ADDR_BITWIDTH-1:0]        rd_addr_q, rd_addr_d;
  logic [15:0]                     acc_q, acc_d, peak_q, peak_d;
  logic [SHIFT_BITWIDTH-1:0]       shift_q, shift_d;
  logic                            wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic                            rd_active_q, rd_active_d;
  logic [BLOCK_COUNT_BITWIDTH-1:0] blk_cnt_q, blk_cnt_d;

  logic                     w_sync, w_accept, w_complete;
  logic [ADDR_BITWIDTH-1:0] w_idx;
  logic [15:0]              w_mag_i, w_mag_q, w_acc_base, w_acc_new;
  logic [SHIFT_BITWIDTH-1:0] w_shift;

  assign w_sync     = bus.syncTo10ms;
  assign w_mag_i    = sat_abs(bus.inData[15:0]);
  assign w_mag_q    = sat_abs(bus.inData[INPUT_DATA_BITWIDTH-1 -: 16]);
  // A sync restarts the block, so a coincident sample lands at index 0.
  assign w_accept   = bus.inValid && (state_q == COLLECT || w_sync);
  assign w_idx      = w_sync ? '0 : count_q;
  assign w_complete = w_accept && (w_idx == LAST_ADDR);
  assign w_acc_base = w_sync ? 16'd0 : acc_q;

  always_comb begin
    w_acc_new = w_acc_base;
    if (w_mag_i > w_acc_new) w_acc_new = w_mag_i;
    if (w_mag_q > w_acc_new) w_acc_new = w_mag_q;
  end

  scaler_block_sequencer_peak_to_shift #(
    .SHIFT_BITWIDTH (SHIFT_BITWIDTH)
  ) u_peak_to_shift (
    .i_peak  (w_acc_new),
    .o_shift (w_shift)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    peak_d      = peak_q;
    shift_d     = shift_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    rd_active_d = rd_active_q;
    rd_addr_d   = rd_addr_q;
    blk_cnt_d   = blk_cnt_q;

    if (w_sync) begin
      state_d   = COLLECT;
      count_d   = '0;
      acc_d     = '0;
      blk_cnt_d = '0;
    end
    if (w_accept) begin
      acc_d   = w_acc_new;
      count_d = w_idx + 1'b1;
    end

    if (rd_active_q) begin
      rd_addr_d = rd_addr_q + 1'b1;
      if (rd_addr_q == LAST_ADDR) rd_active_d = 1'b0;
    end

    // Completion captures the final peak and hands the bank to readout.
    if (w_complete) begin
      count_d     = '0;
      acc_d       = '0;
      peak_d      = w_acc_new;
      shift_d     = w_shift;
      wr_bank_d   = ~wr_bank_q;
      blk_cnt_d   = blk_cnt_q + 1'b1;
      rd_active_d = 1'b1;
      rd_addr_d   = '0;
      rd_bank_d   = wr_bank_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      acc_q       <= '0;
      peak_q      <= '0;
      shift_q     <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_active_q <= 1'b0;
      rd_addr_q   <= '0;
      blk_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      peak_q      <= peak_d;
      shift_q     <= shift_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      rd_active_q <= rd_active_d;
      rd_addr_q   <= rd_addr_d;
      blk_cnt_q   <= blk_cnt_d;
    end
  end

  assign bus.wrEn       = rst && w_accept;
  assign bus.wrBank     = wr_bank_q;
  assign bus.wrAddr     = w_idx;
  assign bus.syncErr    = rst && w_sync && (state_q == COLLECT) && (count_q != '0);
  assign bus.rdEn       = rd_active_q;
  assign bus.rdBank     = rd_bank_q;
  assign bus.rdAddr     = rd_addr_q;
  assign bus.hdrValid   = rd_active_q && (rd_addr_q == '0);
  assign bus.rdLast     = rd_active_q && (rd_addr_q == LAST_ADDR);
  assign bus.blockPeak  = peak_q;
  assign bus.blockShift = shift_q;
  assign bus.blockCount = blk_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_scaler_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_scaler_block_sequencer
// Purpose  : Directed stimulus with queued write/read expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scaler_block_sequencer;

  typedef struct {
    int   cyc;
    logic bank;
    int   addr;
  } wr_t;

  typedef struct {
    int   cyc;
    logic bank;
    int   addr;
    logic hdr;
    logic last;
    int   peak;
    int   shift;
  } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  wr_t wq[$];
  rd_t rq[$];
  wr_t we;
  rd_t re;

  logic m_bank = 1'b0;
  bit   m_collect = 1'b0;
  int   m_count = 0;
  int   m_acc = 0;
  int   m_bc = 0;

  scaler_block_sequencer_if bus ();

  scaler_block_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic int mag(input int x);
    int m;
    m = (x < 0) ? -x : x;
    if (m > 32767) m = 32767;
    return m;
  endfunction

  function automatic int exp_shift(input int p);
    int s;
    int v;
    s = 14;
    v = p;
    while (v > 1) begin
      v = v >> 1;
      s--;
    end
    return s;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic send(input bit v, input bit s, input int iv, input int qv);
    logic [15:0] i16;
    logic [15:0] q16;
    i16 = iv[15:0];
    q16 = qv[15:0];
    @(posedge clk);
    #1;
    bus.inValid    = v;
    bus.syncTo10ms = s;
    bus.inData     = {q16, i16};
    #1;
    if (s) begin
      chk("syncErr", int'(bus.syncErr), int'(m_collect && m_count != 0));
      m_collect = 1'b1;
      m_count   = 0;
      m_acc     = 0;
      m_bc      = 0;
    end
    if (v && m_collect) begin
      wq.push_back('{cyc, m_bank, m_count});
      if (mag(iv) > m_acc) m_acc = mag(iv);
      if (mag(qv) > m_acc) m_acc = mag(qv);
      if (m_count == 1023) begin
        for (int k = 0; k < 1024; k++)
          rq.push_back('{cyc + 1 + k, m_bank, k, k == 0, k == 1023, m_acc, exp_shift(m_acc)});
        m_bank  = ~m_bank;
        m_count = 0;
        m_acc   = 0;
        m_bc++;
      end else begin
        m_count++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus.wrEn) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: wrEn=1 bank=%0d addr=%0d cyc=%0d, required no write",
                 bus.wrBank, bus.wrAddr, cyc);
      end else begin
        we = wq.pop_front();
        if (we.cyc != cyc || we.bank != bus.wrBank || we.addr != int'(bus.wrAddr)) begin
          errors++;
          $display("FAIL wr: got cyc=%0d bank=%0d addr=%0d required cyc=%0d bank=%0d addr=%0d",
                   cyc, bus.wrBank, bus.wrAddr, we.cyc, we.bank, we.addr);
        end
      end
    end else if (wq.size() != 0 && wq[0].cyc <= cyc) begin
      checks++;
      errors++;
      we = wq.pop_front();
      $display("FAIL wr_missing: got wrEn=0 cyc=%0d required write bank=%0d addr=%0d",
               cyc, we.bank, we.addr);
    end

    if (bus.rdEn) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: rdEn=1 addr=%0d cyc=%0d, required no read", bus.rdAddr, cyc);
      end else begin
        re = rq.pop_front();
        if (re.cyc != cyc || re.bank != bus.rdBank || re.addr != int'(bus.rdAddr) ||
            re.hdr != bus.hdrValid || re.last != bus.rdLast ||
            re.peak != int'(bus.blockPeak) || re.shift != int'(bus.blockShift)) begin
          errors++;
          $display("FAIL rd: got cyc=%0d bank=%0d addr=%0d hdr=%0d last=%0d peak=%0d shift=%0d required cyc=%0d bank=%0d addr=%0d hdr=%0d last=%0d peak=%0d shift=%0d",
                   cyc, bus.rdBank, bus.rdAddr, bus.hdrValid, bus.rdLast, bus.blockPeak,
                   bus.blockShift, re.cyc, re.bank, re.addr, re.hdr, re.last, re.peak, re.shift);
        end
      end
    end else if (rq.size() != 0 && rq[0].cyc <= cyc) begin
      checks++;
      errors++;
      re = rq.pop_front();
      $display("FAIL rd_missing: got rdEn=0 cyc=%0d required read bank=%0d addr=%0d",
               cyc, re.bank, re.addr);
    end
  end

  initial begin
    bit found;
    bus.syncTo10ms = 1'b0;
    bus.inValid    = 1'b0;
    bus.inData     = '0;
    #1 rst = 1'b0;
    #2;
    chk("rst_wrEn", int'(bus.wrEn), 0);
    chk("rst_rdEn", int'(bus.rdEn), 0);
    chk("rst_wrBank", int'(bus.wrBank), 0);
    chk("rst_blockPeak", int'(bus.blockPeak), 0);
    chk("rst_blockShift", int'(bus.blockShift), 0);
    chk("rst_blockCount", int'(bus.blockCount), 0);
    chk("rst_syncErr", int'(bus.syncErr), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // Idle samples before any sync must not be written.
    for (int i = 0; i < 3; i++) send(1, 0, 1, 1);

    // Block A: I=+100 Q=-3000, sync coincident with the first sample.
    send(1, 1, 100, -3000);
    for (int i = 1; i < 1024; i++) send(1, 0, 100, -3000);

    // Block B back-to-back, one full-scale negative Q.
    for (int i = 0; i < 1024; i++) begin
      send(1, 0, 100, (i == 500) ? -32768 : -3000);
      if (i == 0) begin
        chk("A_blockCount", int'(bus.blockCount), 1);
        chk("A_blockPeak", int'(bus.blockPeak), 3000);
        chk("A_blockShift", int'(bus.blockShift), 3);
      end
    end

    // Block C: sync at count 0, 1-of-3 valid duty.
    for (int i = 0; i < 3072; i++) begin
      send(i % 3 == 0, i == 0, (i == 300) ? -1500 : 7, 7);
      if (i == 0) chk("B_blockCount", int'(bus.blockCount), 2);
      if (i == 1) begin
        chk("sync_clears_count", int'(bus.blockCount), 0);
        chk("B_blockPeak", int'(bus.blockPeak), 32767);
        chk("B_blockShift", int'(bus.blockShift), 0);
      end
    end

    // Partial block of 500 then an aborting sync; zero block follows.
    for (int i = 0; i < 500; i++) send(1, 0, 200, 200);
    send(1, 1, 0, 0);
    for (int i = 1; i < 1024; i++) begin
      send(1, 0, 0, 0);
      if (i == 1) begin
        chk("abort_blockCount", int'(bus.blockCount), 0);
        chk("syncErr_one_cycle", int'(bus.syncErr), 0);
        chk("abort_same_bank", int'(bus.wrBank), 1);
      end
    end

    // Reset while the zero block is being read out at address 300.
    found = 1'b0;
    for (int n = 0; n < 2100 && !found; n++) begin
      send(0, 0, 0, 0);
      if (bus.rdEn && bus.rdAddr == 10'd300) found = 1'b1;
    end
    if (!found) begin
      chk("rd300_reached", 0, 1);
    end else begin
      chk("zero_blockShift", int'(bus.blockShift), 14);
      #1 rst = 1'b0;
      rq.delete();
      wq.delete();
      m_bank = 1'b0; m_collect = 1'b0; m_count = 0; m_acc = 0; m_bc = 0;
      #1;
      chk("arst_rdEn", int'(bus.rdEn), 0);
      chk("arst_rdAddr", int'(bus.rdAddr), 0);
      chk("arst_blockShift", int'(bus.blockShift), 0);
      chk("arst_blockCount", int'(bus.blockCount), 0);
      chk("arst_rdBank", int'(bus.rdBank), 0);
      send(0, 0, 0, 0);
      send(0, 0, 0, 0);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
        send(1, 0, 9, 9);
        chk("post_rst_wrEn", int'(bus.wrEn), 0);
      end
      send(1, 1, 4, 4);
      send(1, 0, 4, 4);
      send(1, 0, 4, 4);
    end

    for (int i = 0; i < 10; i++) send(0, 0, 0, 0);
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
